morse_sequencer: RTL
====================

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 25000000, meaning clk cycles per Morse time unit (valid range >=2).
REQ-002 SHALL have parameter PAT_W, default 10, meaning pattern width in bits (fixed at 10 for this block).
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enable  input  1  1 = run, 0 = pause (prescaler and outputs hold).
REQ-006 in_valid  input  1  in_pattern is offered.
REQ-007 in_pattern  input  10  Morse pattern, MSB sent first.
REQ-008 in_ready  output  1  word accepted on any edge where in_valid&&in_ready.
REQ-009 tone  output  1  key-down for the current unit.
REQ-010 short  output  1  current symbol is a dot.
REQ-011 l  output  1  current symbol is a dash.
REQ-012 busy  output  1  a pattern is being sequenced.
REQ-013 done  output  1  one-cycle pulse when a pattern completes.
REQ-014 bits_left  output  4  unconsumed bits of current pattern (10..0).

Function
REQ-015 SHALL hold a 1-entry pending buffer; in_ready = !pend_valid.
REQ-016 SHALL decode at each symbol start from shift reg sh and bits_left: sh[9]=0 -> gap (1 unit, consumes 1 bit, tone=0,short=0,l=0); sh[9]=1 && sh[8]=1 && bits_left>=2 -> dash (2 units, consumes 2 bits, tone=1,l=1); else sh[9]=1 -> dot (1 unit, consumes 1 bit, tone=1,short=1).
REQ-017 SHALL therefore spend exactly 10 units (10*TICK_DIV enabled cycles) per pattern.
REQ-018 FSM states IDLE, SYM, DASH2: IDLE->SYM on load; SYM->DASH2 at tick if symbol is dash; SYM/DASH2 -> next SYM at tick after shift; -> IDLE at tick when bits_left becomes 0 and nothing to load.
REQ-019 SHALL load with zero latency: outputs show first symbol decode from the load edge; prescaler cleared to 0 on load.
REQ-020 Prescaler SHALL count 0..TICK_DIV-1 only while busy&&enable; tick = (count==TICK_DIV-1)&&enable; wraps to 0 on tick.
REQ-021 Outputs tone/short/l SHALL change only on load edges, tick edges, or reset.
REQ-022 In IDLE with pend empty, an accepted word SHALL load directly into sh (bypass), pend stays empty.
REQ-023 On the completing tick: done=1 for that cycle; load from pend if pend_valid, else from input if accepted that edge, else go IDLE with tone/short/l=0 — no idle cycle between back-to-back patterns.
REQ-024 enable=0 SHALL freeze prescaler, FSM, sh, outputs; in_valid/in_ready handshake still operates into pend.
REQ-025 A trailing single 1 (bits_left=1) SHALL be a dot, never a dash.

Reset
REQ-026 reset low SHALL immediately force: state IDLE, prescaler 0, sh 0, bits_left 0, pend_valid 0 (pending word dropped), tone/short/l/busy/done 0, in_ready 1.
REQ-027 Reset mid-pattern SHALL abort it without asserting done.

Structure
REQ-028 Package morse_pkg SHALL hold FSM state encoding, PAT_W, default TICK_DIV and symbol class constants.
REQ-029 Prescaler SHALL be a sub-module morse_tick (clk, reset, run, clear -> tick).

Verification (bench TICK_DIV=4)
REQ-030 Reset low -> all outputs 0, in_ready=1; release -> still IDLE.
REQ-031 Load 10'b1101000000 -> l=1 for 8 cycles, gap 4, short=1 for 4, tone=0 for 24, done pulse at cycle 40, busy low next.
REQ-032 Load 10'b0000000001 -> tone=0 for 36 cycles, then short=1 (l=0) 4 cycles, done at 40.
REQ-033 Load 10'b1111111111, offer 10'b1000000000 at cycle 5 -> 5 dashes, in_ready low after accept, second pattern starts at cycle 40 with short=1, done at 40 and 80.
REQ-034 enable=0 for 7 cycles during a dash -> dash lasts 15 cycles, done delayed by 7.
REQ-035 reset low at cycle 13 with a pending word -> outputs 0 same cycle, no done, pending word lost.

Source files
------------

// File: rtl/morse_pkg.sv
// Shared constants, FSM state encoding and symbol classification for the Morse sequencer.
package morse_pkg;

  localparam int unsigned PatW           = 10;
  localparam int unsigned TickDivDefault = 25000000;

  typedef enum logic [1:0] {
    StIdle,
    StSym,
    StDash2
  } state_e;

  typedef enum logic [1:0] {
    SymGap,
    SymDot,
    SymDash
  } sym_e;

  // A dash needs two remaining bits; a lone trailing 1 is always a dot.
  function automatic sym_e decode_sym(input logic msb, input logic nxt,
                                      input logic [3:0] remaining);
    sym_e sym;
    if (!msb) begin
      sym = SymGap;
    end else if (nxt && (remaining >= 4'd2)) begin
      sym = SymDash;
    end else begin
      sym = SymDot;
    end
    return sym;
  endfunction

endpackage

// File: rtl/morse_tick.sv
// Morse time-unit prescaler: counts 0..TICK_DIV-1 while run is high, pulses tick on the last count.
module morse_tick
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = run && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clear || tick) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// Serialises 10-bit Morse patterns (MSB first) into dot/dash/gap units, with a one-word
// pending buffer so consecutive patterns run back to back.
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int unsigned TICK_DIV = TickDivDefault,
  parameter int unsigned PAT_W    = PatW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [PAT_W-1:0] in_pattern,
  output logic             in_ready,
  output logic             tone,
  output logic             short,
  output logic             l,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bits_left
);

  localparam logic [3:0] FullBits = 4'(PAT_W);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] sh_q, sh_d, pend_q, pend_d, sh_shift, load_word;
  logic [3:0]       bits_left_q, bits_left_d, bits_shift;
  logic             pend_valid_q, pend_valid_d;
  logic             tone_q, tone_d, short_q, short_d, l_q, l_d;
  logic             tick, run, accept, advance, complete;
  logic             load_en, load_pend, load_in, load, upd;
  sym_e             cur_sym, next_sym;

  assign busy     = (state_q != StIdle);
  assign run      = busy && enable;
  assign in_ready = !pend_valid_q;
  assign accept   = in_valid && in_ready;

  morse_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .clear(load),
    .tick (tick)
  );

  assign cur_sym = decode_sym(sh_q[PAT_W-1], sh_q[PAT_W-2], bits_left_q);
  // First unit of a dash holds; the symbol is consumed after its second unit.
  assign advance = (state_q == StDash2) || ((state_q == StSym) && (cur_sym != SymDash));

  always_comb begin
    if (state_q == StDash2) begin
      sh_shift   = {sh_q[PAT_W-3:0], 2'b00};
      bits_shift = bits_left_q - 4'd2;
    end else begin
      sh_shift   = {sh_q[PAT_W-2:0], 1'b0};
      bits_shift = bits_left_q - 4'd1;
    end
  end

  assign complete  = tick && advance && (bits_shift == 4'd0);
  assign load_en   = enable && ((state_q == StIdle) || complete);
  assign load_pend = load_en && pend_valid_q;
  assign load_in   = load_en && !pend_valid_q && accept;
  assign load      = load_pend || load_in;
  assign load_word = pend_valid_q ? pend_q : in_pattern;
  assign done      = complete;

  always_comb begin
    state_d     = state_q;
    sh_d        = sh_q;
    bits_left_d = bits_left_q;
    tone_d      = tone_q;
    short_d     = short_q;
    l_d         = l_q;
    next_sym    = SymGap;
    upd         = 1'b0;
    if (load) begin
      state_d     = StSym;
      sh_d        = load_word;
      bits_left_d = FullBits;
      next_sym    = decode_sym(load_word[PAT_W-1], load_word[PAT_W-2], FullBits);
      upd         = 1'b1;
    end else if (tick && !advance) begin
      state_d = StDash2;
    end else if (tick) begin
      upd = 1'b1;
      if (complete) begin
        state_d     = StIdle;
        sh_d        = '0;
        bits_left_d = 4'd0;
      end else begin
        state_d     = StSym;
        sh_d        = sh_shift;
        bits_left_d = bits_shift;
        next_sym    = decode_sym(sh_shift[PAT_W-1], sh_shift[PAT_W-2], bits_shift);
      end
    end
    if (upd) begin
      tone_d  = (next_sym != SymGap);
      short_d = (next_sym == SymDot);
      l_d     = (next_sym == SymDash);
    end
  end

  always_comb begin
    pend_valid_d = pend_valid_q;
    pend_d       = pend_q;
    if (load_pend) begin
      pend_valid_d = 1'b0;
    end else if (accept && !load_in) begin
      pend_valid_d = 1'b1;
      pend_d       = in_pattern;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      sh_q         <= '0;
      pend_q       <= '0;
      bits_left_q  <= 4'd0;
      pend_valid_q <= 1'b0;
      tone_q       <= 1'b0;
      short_q      <= 1'b0;
      l_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      sh_q         <= sh_d;
      pend_q       <= pend_d;
      bits_left_q  <= bits_left_d;
      pend_valid_q <= pend_valid_d;
      tone_q       <= tone_d;
      short_q      <= short_d;
      l_q          <= l_d;
    end
  end

  assign tone      = tone_q;
  assign short     = short_q;
  assign l         = l_q;
  assign bits_left = bits_left_q;

endmodule
